// File: rtl/btb_pkg.sv
// Shared types, constants and helpers for the set-associative branch target buffer.
package btb_pkg;

  // Default field widths for a BTB entry. The top-level ADDR_W and CNT_W
  // parameters default to these values and must match them.
  localparam int unsigned BTB_ADDR_W = 32;
  localparam int unsigned BTB_CNT_W  = 2;

  // Direction counter values used at reset and on allocation.
  localparam logic [BTB_CNT_W-1:0] CNT_WEAK_NT = 2'b01;
  localparam logic [BTB_CNT_W-1:0] CNT_WEAK_T  = 2'b10;

  // One BTB way. The tag holds PC >> (IDX_W+2), zero-extended to full width,
  // so the same struct serves any SETS value.
  typedef struct packed {
    logic                  valid;
    logic                  uncond;
    logic [BTB_ADDR_W-1:0] tag;
    logic [BTB_ADDR_W-1:0] target;
    logic [BTB_CNT_W-1:0]  cnt;
  } btb_entry_t;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  function automatic logic [BTB_CNT_W-1:0] sat_inc(input logic [BTB_CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  function automatic logic [BTB_CNT_W-1:0] sat_dec(input logic [BTB_CNT_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

endpackage

// File: rtl/btb_plru.sv
// Per-set pseudo-LRU replacement state: 1 bit for 2 ways, a 3-bit tree for 4 ways,
// nothing for 1 way. The same set is both touched and queried for a victim.
module btb_plru
  import btb_pkg::*;
#(
  parameter  int unsigned SETS  = 256,
  parameter  int unsigned WAYS  = 2,
  localparam int unsigned IDX_W = clog2(SETS),
  localparam int unsigned WAY_W = (WAYS > 1) ? clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] set_i,
  input  logic             touch_en_i,
  input  logic [WAY_W-1:0] touch_way_i,
  output logic [WAY_W-1:0] victim_way_o
);

  if (WAYS == 1) begin : g_one
    assign victim_way_o = '0;
  end else if (WAYS == 2) begin : g_two
    logic plru_q [SETS];

    assign victim_way_o = plru_q[set_i];

    // Point the set's bit away from the way just used.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++) plru_q[s] <= 1'b0;
      end else if (touch_en_i) begin
        plru_q[set_i] <= ~touch_way_i[0];
      end
    end
  end else begin : g_four
    // Bit 0 picks the half (0 = ways 0/1), bit 1 the way within 0/1, bit 2 within 2/3.
    logic [2:0] plru_q [SETS];
    logic [2:0] cur, plru_d;

    // Tree update: every bit on the path to the touched way points away from it.
    // NOTE: plru_d takes a full default first so no path leaves it unassigned (no latch).
    always_comb begin
      cur       = plru_q[set_i];
      plru_d    = cur;
      plru_d[0] = ~touch_way_i[1];
      if (touch_way_i[1]) plru_d[2] = ~touch_way_i[0];
      else                plru_d[1] = ~touch_way_i[0];
    end

    assign victim_way_o = cur[0] ? {1'b1, cur[2]} : {1'b0, cur[1]};

    // Store the updated tree for the touched set.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++) plru_q[s] <= 3'b000;
      end else if (touch_en_i) begin
        plru_q[set_i] <= plru_d;
      end
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: combinational next-PC prediction with
// per-entry saturating direction counters, pLRU replacement and commit-time update.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int unsigned ADDR_W   = BTB_ADDR_W,
  parameter int unsigned SETS     = 256,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned CNT_W    = BTB_CNT_W,
  parameter bit          USE_GPRE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PC_in,
  input  logic              Gpre,
  input  logic [ADDR_W-1:0] old_PC,
  input  logic [ADDR_W-1:0] check_Addr,
  input  logic              is_Branch,
  input  logic              is_Jump,
  input  logic              taken,
  input  logic              update_En,
  input  logic              Remedy,
  input  logic              update_Choice,
  output logic              Choice,
  output logic              Hit,
  output logic [ADDR_W-1:0] NEXT_PC
);

  localparam int unsigned IDX_W = clog2(SETS);
  localparam int unsigned WAY_W = (WAYS > 1) ? clog2(WAYS) : 1;

  btb_entry_t mem_q [SETS][WAYS];

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [ADDR_W-1:0] lk_tag, up_tag;
  logic              lk_hit, up_hit, inv_found;
  logic [WAY_W-1:0]  lk_way, up_way, inv_way, victim_way, wr_way;
  logic              take, wr_en, dir_bit, pt;
  btb_entry_t        entry_d;

  assign lk_idx = PC_in[IDX_W+1:2];
  assign lk_tag = PC_in >> (IDX_W + 2);
  assign up_idx = old_PC[IDX_W+1:2];
  assign up_tag = old_PC >> (IDX_W + 2);

  // Fetch-side lookup: at most one way of the set can match.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (mem_q[lk_idx][w].valid && mem_q[lk_idx][w].tag == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  // Commit-side lookup of old_PC, plus the lowest-index free way of its set.
  always_comb begin
    up_hit    = 1'b0;
    up_way    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (mem_q[up_idx][w].valid && mem_q[up_idx][w].tag == up_tag) begin
        up_hit = 1'b1;
        up_way = WAY_W'(w);
      end
      if (!mem_q[up_idx][w].valid && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  btb_plru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_plru (
    .clk          (clk),
    .rst          (rst),
    .set_i        (up_idx),
    .touch_en_i   (wr_en),
    .touch_way_i  (wr_way),
    .victim_way_o (victim_way)
  );

  // A hit always rewrites its way; a miss allocates only for taken branches and jumps.
  assign take   = taken | is_Jump;
  assign wr_en  = update_En & (is_Branch | is_Jump) & (up_hit | take);
  assign wr_way = up_hit ? up_way : (inv_found ? inv_way : victim_way);

  // New contents of the written way.
  always_comb begin
    entry_d        = '0;
    entry_d.valid  = 1'b1;
    entry_d.uncond = is_Jump;
    entry_d.tag    = up_tag;
    entry_d.target = check_Addr;
    entry_d.cnt    = CNT_WEAK_T;
    if (up_hit) begin
      entry_d.cnt = take ? sat_inc(mem_q[up_idx][up_way].cnt)
                         : sat_dec(mem_q[up_idx][up_way].cnt);
    end
  end

  // Entry storage; reset has priority over a same-cycle commit.
  // NOTE: only valid/uncond/cnt are reset -- tag and target are meaningless while
  // valid=0, so leaving them unreset keeps the storage free of reset fan-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          mem_q[s][w].valid  <= 1'b0;
          mem_q[s][w].uncond <= 1'b0;
          mem_q[s][w].cnt    <= CNT_WEAK_NT;
        end
      end
    end else if (wr_en) begin
      mem_q[up_idx][wr_way] <= entry_d;
    end
  end

  assign dir_bit = USE_GPRE ? Gpre : mem_q[lk_idx][lk_way].cnt[CNT_W-1];
  assign pt      = lk_hit & (mem_q[lk_idx][lk_way].uncond | dir_bit);

  // Next-PC select: the mispredict redirect overrides the prediction.
  always_comb begin
    Hit     = lk_hit;
    Choice  = 1'b0;
    NEXT_PC = PC_in + ADDR_W'(4);
    if (Remedy) begin
      NEXT_PC = update_Choice ? check_Addr : old_PC + ADDR_W'(4);
    end else if (pt) begin
      NEXT_PC = mem_q[lk_idx][lk_way].target;
      Choice  = 1'b1;
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc (SETS=256, WAYS=2): directed vector table,
// a counter-saturation sequence, then randomized traffic against a reference model.
module tb_btb_assoc;

  localparam int SETS  = 256;
  localparam int WAYS  = 2;
  localparam int IDX_W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0, old_pc = '0, check_addr = '0;
  logic        gpre = 1'b0, is_branch = 1'b0, is_jump = 1'b0, taken = 1'b0;
  logic        update_en = 1'b0, remedy = 1'b0, update_choice = 1'b0;
  logic        choice, hit;
  logic [31:0] next_pc;

  always #5 clk = ~clk;

  btb_assoc #(
    .ADDR_W   (32),
    .SETS     (SETS),
    .WAYS     (WAYS),
    .CNT_W    (2),
    .USE_GPRE (1'b0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PC_in         (pc_in),
    .Gpre          (gpre),
    .old_PC        (old_pc),
    .check_Addr    (check_addr),
    .is_Branch     (is_branch),
    .is_Jump       (is_jump),
    .taken         (taken),
    .update_En     (update_en),
    .Remedy        (remedy),
    .update_Choice (update_choice),
    .Choice        (choice),
    .Hit           (hit),
    .NEXT_PC       (next_pc)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        r;
    logic [31:0] pc, opc, chk;
    logic        br, jmp, tk, upd, rem, uch;
    logic        eh, ec;
    logic [31:0] en;
  } vec_t;

  function automatic vec_t v(input logic r, input logic [31:0] pc, opc, chk,
                             input logic br, jmp, tk, upd, rem, uch,
                             input logic eh, ec, input logic [31:0] en);
    vec_t t;
    t.r = r; t.pc = pc; t.opc = opc; t.chk = chk;
    t.br = br; t.jmp = jmp; t.tk = tk; t.upd = upd; t.rem = rem; t.uch = uch;
    t.eh = eh; t.ec = ec; t.en = en;
    return t;
  endfunction

  // Drive one cycle of inputs at the falling edge, then compare the combinational outputs.
  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    rst = t.r; pc_in = t.pc; old_pc = t.opc; check_addr = t.chk;
    is_branch = t.br; is_jump = t.jmp; taken = t.tk; update_en = t.upd;
    remedy = t.rem; update_choice = t.uch; gpre = 1'b0;
    #1;
    check({tag, " Hit"}, 32'(hit), 32'(t.eh));
    check({tag, " Choice"}, 32'(choice), 32'(t.ec));
    check({tag, " NEXT_PC"}, next_pc, t.en);
  endtask

  // ---------------- reference model (true LRU; identical to pLRU for 2 ways) ----------
  bit          m_valid [SETS][WAYS];
  bit          m_unc   [SETS][WAYS];
  logic [31:0] m_tag   [SETS][WAYS];
  logic [31:0] m_tgt   [SETS][WAYS];
  int          m_cnt   [SETS][WAYS];
  int unsigned m_stamp [SETS][WAYS];
  int unsigned m_time;

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0; m_unc[s][w] = 0; m_cnt[s][w] = 1; m_stamp[s][w] = 0;
      end
    m_time = 0;
  endfunction

  function automatic int m_set(input logic [31:0] pc);
    return int'((pc >> 2) % SETS);
  endfunction

  function automatic int m_find(input logic [31:0] pc);
    int s = m_set(pc);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == (pc >> (IDX_W + 2))) return w;
    return -1;
  endfunction

  function automatic void m_commit(input logic [31:0] opc, chk, input bit br, jmp, tk);
    int s = m_set(opc);
    int w = m_find(opc);
    bit take = tk || jmp;
    if (!(br || jmp)) return;
    if (w >= 0) begin
      m_cnt[s][w] = take ? ((m_cnt[s][w] < 3) ? m_cnt[s][w] + 1 : 3)
                         : ((m_cnt[s][w] > 0) ? m_cnt[s][w] - 1 : 0);
    end else if (take) begin
      w = -1;
      for (int i = 0; i < WAYS; i++) if (!m_valid[s][i] && w < 0) w = i;
      if (w < 0) begin
        w = 0;
        for (int i = 1; i < WAYS; i++) if (m_stamp[s][i] < m_stamp[s][w]) w = i;
      end
      m_valid[s][w] = 1; m_tag[s][w] = opc >> (IDX_W + 2); m_cnt[s][w] = 2;
    end else begin
      return;
    end
    m_unc[s][w] = jmp; m_tgt[s][w] = chk;
    m_time++; m_stamp[s][w] = m_time;
  endfunction

  function automatic logic [31:0] rnd_pc();
    logic [31:0] tag;
    case ($urandom_range(0, 3))
      0:       tag = 32'h0;
      1:       tag = 32'h1;
      2:       tag = 32'h5A5A5;
      default: tag = 32'h3FFFFF;
    endcase
    return (tag << 10) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  vec_t tbl[$];

  initial begin
    // Directed vectors: {rst, PC_in, old_PC, check_Addr, br, jmp, tk, upd, rem, uch, Hit, Choice, NEXT_PC}
    tbl.push_back(v(1, 'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h1004));
    tbl.push_back(v(0, 'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h1004));
    tbl.push_back(v(0, 'h1000, 'h1000, 'h2000, 0, 1, 0, 1, 0, 0, 0, 0, 'h1004));
    tbl.push_back(v(0, 'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h2000));
    tbl.push_back(v(0, 'h3000, 'h3000, 'h3400, 1, 0, 1, 1, 0, 0, 0, 0, 'h3004));
    tbl.push_back(v(0, 'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h3400));
    tbl.push_back(v(0, 'h3000, 'h3000, 'h3400, 1, 0, 0, 1, 0, 0, 1, 1, 'h3400));
    tbl.push_back(v(0, 'h3000, 'h3000, 'h3400, 1, 0, 0, 1, 0, 0, 1, 0, 'h3004));
    tbl.push_back(v(0, 'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h3004));
    tbl.push_back(v(0, 'h3000, 'h3000, 'h3400, 1, 0, 1, 1, 0, 0, 1, 0, 'h3004));
    tbl.push_back(v(0, 'h3000, 'h3000, 'h3400, 1, 0, 1, 1, 0, 0, 1, 0, 'h3004));
    tbl.push_back(v(0, 'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h3400));
    tbl.push_back(v(0, 'h1000, 'h4000, 'h5000, 0, 0, 0, 0, 1, 1, 1, 0, 'h5000));
    tbl.push_back(v(0, 'h1000, 'h4000, 'h5000, 0, 0, 0, 0, 1, 0, 1, 0, 'h4004));
    tbl.push_back(v(0, 'h1000, 'hFFFF_FFFC, 'h5000, 0, 0, 0, 0, 1, 0, 1, 0, 'h0));
    tbl.push_back(v(0, 'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h0));
    tbl.push_back(v(1, 'h8000, 'h6000, 'h7000, 0, 1, 0, 1, 0, 0, 0, 0, 'h8004));
    tbl.push_back(v(0, 'h6000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h6004));
    tbl.push_back(v(0, 'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h1004));
    tbl.push_back(v(0, 'h1000, 'h1000, 'h1100, 1, 0, 1, 1, 0, 0, 0, 0, 'h1004));
    tbl.push_back(v(0, 'h1000, 'h10_1000, 'h10_1100, 1, 0, 1, 1, 0, 0, 1, 1, 'h1100));
    tbl.push_back(v(0, 'h10_1000, 'h20_1000, 'h20_1100, 1, 0, 1, 1, 0, 0, 1, 1, 'h10_1100));
    tbl.push_back(v(0, 'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h1004));
    tbl.push_back(v(0, 'h10_1000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h10_1100));
    tbl.push_back(v(0, 'h20_1000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h20_1100));
    tbl.push_back(v(0, 'h6000, 'h6000, 'h7000, 0, 1, 0, 1, 0, 0, 0, 0, 'h6004));
    tbl.push_back(v(0, 'h6000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h7000));
    tbl.push_back(v(0, 'h8000, 'h8000, 'h9000, 0, 0, 1, 1, 0, 0, 0, 0, 'h8004));
    tbl.push_back(v(0, 'h8000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h8004));
    tbl.push_back(v(0, 'h8000, 'h8000, 'h9000, 1, 0, 0, 1, 0, 0, 0, 0, 'h8004));
    tbl.push_back(v(0, 'h8000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h8004));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

    // Counter saturation at 0xA000: 10 -> 11 -> 11 -> 10 -> 01.
    apply(v(0, 'hA000, 'hA000, 'hA800, 1, 0, 1, 1, 0, 0, 0, 0, 'hA004), "sat0");
    apply(v(0, 'hA000, 'hA000, 'hA800, 1, 0, 1, 1, 0, 0, 1, 1, 'hA800), "sat1");
    apply(v(0, 'hA000, 'hA000, 'hA800, 1, 0, 1, 1, 0, 0, 1, 1, 'hA800), "sat2");
    apply(v(0, 'hA000, 'hA000, 'hA800, 1, 0, 0, 1, 0, 0, 1, 1, 'hA800), "sat3");
    apply(v(0, 'hA000, 'hA000, 'hA800, 1, 0, 0, 1, 0, 0, 1, 1, 'hA800), "sat4");
    apply(v(0, 'hA000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'hA004), "sat5");

    // Randomized traffic against the reference model.
    apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h4), "rnd_rst");
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      int          s, w;
      bit          e_hit, e_pt;
      logic [31:0] e_next;
      @(negedge clk);
      rst           = ($urandom_range(0, 199) == 0);
      pc_in         = rnd_pc();
      old_pc        = rnd_pc();
      check_addr    = $urandom;
      is_branch     = $urandom_range(0, 1) == 1;
      is_jump       = $urandom_range(0, 3) == 0;
      taken         = $urandom_range(0, 1) == 1;
      update_en     = $urandom_range(0, 2) != 0;
      remedy        = $urandom_range(0, 7) == 0;
      update_choice = $urandom_range(0, 1) == 1;
      gpre          = $urandom_range(0, 1) == 1;
      #1;
      s      = m_set(pc_in);
      w      = m_find(pc_in);
      e_hit  = (w >= 0);
      e_pt   = e_hit && (m_unc[s][w] || m_cnt[s][w] >= 2);
      e_next = remedy ? (update_choice ? check_addr : old_pc + 32'd4)
                      : (e_pt ? m_tgt[s][w] : pc_in + 32'd4);
      check($sformatf("rnd%0d Hit", n), 32'(hit), 32'(e_hit));
      check($sformatf("rnd%0d Choice", n), 32'(choice), 32'(e_pt && !remedy));
      check($sformatf("rnd%0d NEXT_PC", n), next_pc, e_next);
      if (rst) m_reset();
      else if (update_en) m_commit(old_pc, check_addr, is_branch, is_jump, taken);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
